// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module : uart_program_loader
// Receives a length-prefixed program image over 8N1 UART and writes it word
// by word into memory; load_done releases the core once the image is in place.
// Rev    : 1.0
// ============================================================================
module uart_program_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [15:0] BASE_ADDR    = 16'd0
) (
  input  logic        fast_clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        load_done,
  output logic        frame_err,
  output logic [15:0] words_loaded
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] HDR_HI = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] WORD   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  logic             rx_meta;
  logic             rx_sync;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid;
  logic             frame_fail;

  logic [2:0]       ld_state;
  logic [15:0]      n_words;
  logic [1:0]       byte_idx;
  logic [23:0]      word_acc;

  // Reset value 1 keeps an idle line from looking like a start bit.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
      frame_fail <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_fail <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt  <= '0;
            bit_idx  <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_FULL) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          if (clk_cnt == CNT_FULL) begin
            clk_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
              frame_fail <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // A completed load stays complete; a later line error only raises frame_err.
  always_ff @(posedge fast_clk) begin
    if (reset) begin
      ld_state     <= HDR_HI;
      n_words      <= 16'd0;
      byte_idx     <= 2'd0;
      word_acc     <= 24'd0;
      mem_addr     <= 16'd0;
      mem_din      <= 32'd0;
      words_loaded <= 16'd0;
    end else if (frame_fail && ld_state != DONE) begin
      ld_state <= ERR;
    end else begin
      case (ld_state)
        HDR_HI: begin
          if (byte_valid) begin
            n_words[15:8] <= rx_shift;
            ld_state      <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (byte_valid) begin
            n_words[7:0] <= rx_shift;
            byte_idx     <= 2'd0;
            ld_state     <= ({n_words[15:8], rx_shift} == 16'd0) ? DONE : WORD;
          end
        end
        WORD: begin
          if (byte_valid) begin
            if (byte_idx == 2'd3) begin
              mem_din  <= {word_acc, rx_shift};
              mem_addr <= BASE_ADDR + words_loaded;
              ld_state <= WRITE;
            end else begin
              word_acc <= {word_acc[15:0], rx_shift};
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          byte_idx     <= 2'd0;
          ld_state     <= ((words_loaded + 16'd1) == n_words) ? DONE : WORD;
        end
        default: ld_state <= ld_state;
      endcase
    end
  end

  assign mem_en    = (ld_state == WRITE);
  assign mem_wen   = (ld_state == WRITE);
  assign load_done = (ld_state == DONE);

endmodule
`default_nettype wire
